// File: rtl/tlc5620_pkg.sv
// rtl/tlc5620_pkg.sv - shared widths, FSM states and frame packing for the TLC5620 controller
package tlc5620_pkg;

  localparam int FRAME_W = 11;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 2;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    GAP,
    LOAD,
    LDAC
  } state_t;

  // TLC5620 serial frame: channel address, range bit, then the 8-bit code, MSB first
  function automatic logic [FRAME_W-1:0] pack_frame(input logic [ADDR_W-1:0] addr,
                                                    input logic              rng,
                                                    input logic [DATA_W-1:0] data);
    return {addr, rng, data};
  endfunction

endpackage

// File: rtl/tlc5620_rr_arbiter.sv
// rtl/tlc5620_rr_arbiter.sv - picks the first dirty channel at or after rr_ptr, wrapping
module tlc5620_rr_arbiter
  import tlc5620_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0] dirty,
  input  logic [ADDR_W-1:0] rr_ptr,
  output logic [ADDR_W-1:0] grant,
  output logic              valid
);

  localparam logic [ADDR_W:0] NCH = (ADDR_W + 1)'(NUM_CH);

  logic [2*NUM_CH-1:0] dbl;
  logic [2*NUM_CH-1:0] rot;
  logic [2*NUM_CH-1:0] probe;
  logic [ADDR_W-1:0]   off;
  logic                found;
  logic [ADDR_W:0]     sum;
  logic [ADDR_W:0]     wrap;

  assign valid = |dirty;

  // Rotate the doubled request vector so rr_ptr lands at bit 0, find the first request,
  // then map the offset back to an absolute channel number modulo NUM_CH.
  always_comb begin
    dbl   = {dirty, dirty};
    rot   = dbl >> rr_ptr;
    probe = '0;
    off   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      probe = rot >> k;
      if (!found && probe[0]) begin
        found = 1'b1;
        off   = ADDR_W'(k);
      end
    end
    sum   = {1'b0, rr_ptr} + {1'b0, off};
    wrap  = sum - NCH;
    grant = (sum >= NCH) ? wrap[ADDR_W-1:0] : sum[ADDR_W-1:0];
  end

endmodule

// File: rtl/tlc5620_multi_ch_ctrl.sv
// rtl/tlc5620_multi_ch_ctrl.sv - shadowed multi-channel serial controller for the TLC5620 DAC
module tlc5620_multi_ch_ctrl
  import tlc5620_pkg::*;
#(
  parameter int CLK_DIV   = 25,
  parameter int NUM_CH    = 4,
  parameter int LDAC_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_ch,
  input  logic              wr_rng,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              da_clk,
  output logic              da_sda,
  output logic              da_load,
  output logic              da_ldac
);

  localparam int                SH_W     = DATA_W + 1;
  localparam int                SH_TOT   = SH_W * NUM_CH;
  localparam int                DIV_W    = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [ADDR_W:0]   NCH      = (ADDR_W + 1)'(NUM_CH);
  localparam logic [ADDR_W-1:0] LAST_CH  = ADDR_W'(NUM_CH - 1);
  localparam logic [SH_TOT-1:0] SH_MASK  = SH_TOT'({SH_W{1'b1}});

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [3:0]           bit_q, bit_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic [ADDR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NUM_CH-1:0]    dirty_q, dirty_d;
  logic [SH_TOT-1:0]    shadow_q, shadow_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 da_clk_q, da_clk_d;
  logic                 da_sda_q, da_sda_d;
  logic                 da_load_q, da_load_d;
  logic                 da_ldac_q, da_ldac_d;

  logic                 wr_hit;
  logic [NUM_CH-1:0]    dirty_set;
  logic [NUM_CH-1:0]    grant_oh;
  logic [ADDR_W-1:0]    arb_grant;
  logic                 arb_valid;
  logic [SH_TOT-1:0]    sel_word;
  logic [FRAME_W-1:0]   frame_word;
  logic                 div_end;
  logic                 take;

  tlc5620_rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .dirty  (dirty_q),
    .rr_ptr (rr_ptr_q),
    .grant  (arb_grant),
    .valid  (arb_valid)
  );

  // Writes to channels the build does not service are dropped here
  assign wr_hit     = wr_en && ({1'b0, wr_ch} < NCH);
  assign dirty_set  = wr_hit ? (NUM_CH'(1) << wr_ch) : '0;
  assign grant_oh   = NUM_CH'(1) << arb_grant;
  assign sel_word   = shadow_q >> (SH_W * arb_grant);
  assign frame_word = pack_frame(arb_grant, sel_word[SH_W-1], sel_word[DATA_W-1:0]);
  assign div_end    = (div_q == DIV_LAST);

  assign busy    = busy_q;
  assign done    = done_q;
  assign da_clk  = da_clk_q;
  assign da_sda  = da_sda_q;
  assign da_load = da_load_q;
  assign da_ldac = da_ldac_q;

  // Shadow registers: host writes land immediately, independent of the scanner
  always_comb begin
    shadow_d = shadow_q;
    if (wr_hit) begin
      shadow_d = (shadow_q & ~(SH_MASK << (SH_W * wr_ch)))
               | (SH_TOT'({wr_rng, wr_data}) << (SH_W * wr_ch));
    end
  end

  // Scanner FSM: pick a dirty channel, shift its frame, then LOAD and (per mode) LDAC
  always_comb begin
    state_d   = state_q;
    div_d     = div_end ? '0 : div_q + DIV_W'(1);
    bit_d     = bit_q;
    shift_d   = shift_q;
    rr_ptr_d  = rr_ptr_q;
    take      = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    da_clk_d  = da_clk_q;
    da_sda_d  = da_sda_q;
    da_load_d = da_load_q;
    da_ldac_d = da_ldac_q;

    case (state_q)
      IDLE: begin
        div_d = '0;
        if (arb_valid) begin
          take     = 1'b1;
          shift_d  = frame_word;
          da_clk_d = 1'b1;
          da_sda_d = frame_word[FRAME_W-1];
          bit_d    = 4'(FRAME_W - 1);
          rr_ptr_d = (arb_grant == LAST_CH) ? '0 : arb_grant + ADDR_W'(1);
          busy_d   = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (div_end) begin
          if (da_clk_q) begin
            // falling edge mid-bit: the DAC samples da_sda here
            da_clk_d = 1'b0;
          end else if (bit_q == 4'd0) begin
            da_sda_d = 1'b0;
            state_d  = GAP;
          end else begin
            bit_d    = bit_q - 4'd1;
            shift_d  = {shift_q[FRAME_W-2:0], 1'b0};
            da_clk_d = 1'b1;
            da_sda_d = shift_q[FRAME_W-2];
          end
        end
      end
      GAP: begin
        if (div_end) begin
          da_load_d = 1'b0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (div_end) begin
          da_load_d = 1'b1;
          if ((LDAC_MODE == 1) && (|dirty_q)) begin
            // batch mode: keep draining before the single LDAC
            state_d = IDLE;
          end else begin
            da_ldac_d = 1'b0;
            state_d   = LDAC;
          end
        end
      end
      LDAC: begin
        if (div_end) begin
          da_ldac_d = 1'b1;
          done_d    = 1'b1;
          busy_d    = |(dirty_q | dirty_set);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A write arriving in the same cycle as the grant keeps the channel dirty
    dirty_d = dirty_q;
    if (take) begin
      dirty_d = dirty_d & ~grant_oh;
    end
    dirty_d = dirty_d | dirty_set;
  end

  // State and output registers with asynchronous reset to the idle pin levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      rr_ptr_q  <= '0;
      dirty_q   <= '0;
      shadow_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      da_clk_q  <= 1'b0;
      da_sda_q  <= 1'b0;
      da_load_q <= 1'b1;
      da_ldac_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      rr_ptr_q  <= rr_ptr_d;
      dirty_q   <= dirty_d;
      shadow_q  <= shadow_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      da_clk_q  <= da_clk_d;
      da_sda_q  <= da_sda_d;
      da_load_q <= da_load_d;
      da_ldac_q <= da_ldac_d;
    end
  end

endmodule
